// File: rtl/trigger_sequencer.sv
// Trigger sequencer: delay / pulse / gap burst generator driving the ME0 front-end trigger.
// Latency: trig_out rises delay+1 cycles after the start (mode 0) or external-edge (mode 1) sample cycle.
// Backpressure: none; config is snapshotted on an accepted start, and stop/enable-low abort on the next cycle.
module trigger_sequencer #(
  parameter int CNT_W = 32,
  parameter int WID_W = 8
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             cfg_enable,
  input  logic             cfg_start,
  input  logic             cfg_stop,
  input  logic             cfg_mode,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic [WID_W-1:0] cfg_width,
  input  logic             ext_trig_in,
  output logic             trig_out,
  output logic             busy,
  output logic             done,
  output logic             overrun,
  output logic [CNT_W-1:0] trig_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    DELAY = 3'd2,
    PULSE = 3'd3,
    GAP   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Length-minus-one of a timed state; a zero length is stretched to one cycle.
  function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] len);
    return (len == '0) ? '0 : (len - CNT_ONE);
  endfunction

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;        // cycles left in the current timed state, minus one

  // Run snapshot, frozen for the whole burst
  logic             mode_q;
  logic [CNT_W-1:0] delay_q;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] count_q;
  logic [WID_W-1:0] width_q;

  // External trigger history; vld stays low until one real sample has been taken after reset,
  // so a trigger that is already high when reset releases is never seen as a rising edge.
  logic             ext_prev_q;
  logic             ext_vld_q;

  // Registered outputs
  logic             trig_out_q;
  logic             busy_q;
  logic             done_q;
  logic             overrun_q;
  logic [CNT_W-1:0] trig_cnt_q;

  logic             halt;
  logic             start_acc;
  logic             ext_rise;
  logic             enter_pulse;
  logic             last_pulse;
  logic [CNT_W-1:0] width_sel;
  logic [CNT_W-1:0] pulse_m1;
  logic [CNT_W-1:0] gap_m1;
  logic [CNT_W-1:0] trig_cnt_pulse;

  // Stop and enable-low share one abort path; stop beats a coincident start.
  assign halt      = cfg_stop | ~cfg_enable;
  assign start_acc = (state_q == IDLE) & cfg_start & ~halt;
  assign ext_rise  = ext_vld_q & ext_trig_in & ~ext_prev_q;

  // A start that goes straight to PULSE must use the live config, later pulses the snapshot.
  assign width_sel = (state_q == IDLE) ? CNT_W'(cfg_width) : CNT_W'(width_q);
  assign pulse_m1  = len_m1(width_sel);
  assign gap_m1    = len_m1(period_q);

  // First pulse of a run restarts the counter at one; later pulses saturate at all-ones.
  assign trig_cnt_pulse = (state_q == IDLE)      ? CNT_ONE :
                          (trig_cnt_q == CNT_MAX) ? trig_cnt_q : (trig_cnt_q + CNT_ONE);

  // trig_cnt already includes the pulse currently being driven.
  assign last_pulse = (count_q != '0) && (trig_cnt_q == count_q);

  // Every path that makes PULSE the next state, gathered so the entry actions live in one place.
  always_comb begin
    enter_pulse = 1'b0;
    unique case (state_q)
      IDLE:    enter_pulse = start_acc && !cfg_mode && (cfg_delay == '0);
      ARMED:   enter_pulse = ext_rise && (delay_q == '0);
      DELAY:   enter_pulse = (cnt_q == '0);
      GAP:     enter_pulse = (cnt_q == '0) && !mode_q;
      default: enter_pulse = 1'b0;
    endcase
  end

  // Sequencer FSM with registered trigger and status outputs.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mode_q     <= 1'b0;
      delay_q    <= '0;
      period_q   <= '0;
      count_q    <= '0;
      width_q    <= '0;
      ext_prev_q <= 1'b0;
      ext_vld_q  <= 1'b0;
      trig_out_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
      trig_cnt_q <= '0;
    end else begin
      ext_prev_q <= ext_trig_in;
      ext_vld_q  <= 1'b1;

      if (halt) begin
        // Abort: done and trig_cnt keep their values for the register bank to read.
        state_q    <= IDLE;
        cnt_q      <= '0;
        trig_out_q <= 1'b0;
        busy_q     <= 1'b0;
      end else begin
        // An edge arriving while a triggered sequence is still running is dropped and flagged.
        if (mode_q && ext_rise && (state_q inside {DELAY, PULSE, GAP})) begin
          overrun_q <= 1'b1;
        end

        if (start_acc) begin
          mode_q     <= cfg_mode;
          delay_q    <= cfg_delay;
          period_q   <= cfg_period;
          count_q    <= cfg_count;
          width_q    <= cfg_width;
          trig_cnt_q <= '0;
          done_q     <= 1'b0;
          overrun_q  <= 1'b0;
        end

        if (enter_pulse) begin
          state_q    <= PULSE;
          cnt_q      <= pulse_m1;
          trig_out_q <= 1'b1;
          busy_q     <= 1'b1;
          trig_cnt_q <= trig_cnt_pulse;
        end else begin
          unique case (state_q)
            IDLE: begin
              if (start_acc) begin
                busy_q <= 1'b1;
                if (cfg_mode) begin
                  state_q <= ARMED;
                end else begin
                  state_q <= DELAY;
                  cnt_q   <= cfg_delay - CNT_ONE;
                end
              end
            end
            ARMED: begin
              if (ext_rise) begin
                state_q <= DELAY;
                cnt_q   <= delay_q - CNT_ONE;
              end
            end
            DELAY: begin
              cnt_q <= cnt_q - CNT_ONE;
            end
            PULSE: begin
              if (cnt_q == '0) begin
                trig_out_q <= 1'b0;
                if (last_pulse) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                end else begin
                  state_q <= GAP;
                  cnt_q   <= gap_m1;
                end
              end else begin
                cnt_q <= cnt_q - CNT_ONE;
              end
            end
            GAP: begin
              // Mode 0 gap expiry is taken by enter_pulse; only mode 1 re-arms here.
              if (cnt_q == '0) begin
                state_q <= ARMED;
              end else begin
                cnt_q <= cnt_q - CNT_ONE;
              end
            end
            default: begin
              state_q    <= IDLE;
              trig_out_q <= 1'b0;
              busy_q     <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign trig_out = trig_out_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overrun  = overrun_q;
  assign trig_cnt = trig_cnt_q;

  // The trigger line may only be high while the FSM sits in PULSE.
  a_trig_in_pulse: assert property (@(posedge ACLK) disable iff (ARESET)
    trig_out_q |-> (state_q == PULSE));

  // busy mirrors "not IDLE".
  a_busy_state: assert property (@(posedge ACLK) disable iff (ARESET)
    busy_q == (state_q != IDLE));

endmodule

// File: tb/tb_trigger_sequencer.sv
// Testbench for trigger_sequencer: table of burst scenarios checked cycle by cycle,
// followed by hand-written sequences for snapshotting, asynchronous reset and start/stop rules.
module tb_trigger_sequencer;

  logic        ACLK;
  logic        ARESET;
  logic        cfg_enable;
  logic        cfg_start;
  logic        cfg_stop;
  logic        cfg_mode;
  logic [31:0] cfg_delay;
  logic [31:0] cfg_period;
  logic [31:0] cfg_count;
  logic [7:0]  cfg_width;
  logic        ext_trig_in;
  logic        trig_out;
  logic        busy;
  logic        done;
  logic        overrun;
  logic [31:0] trig_cnt;

  trigger_sequencer #(.CNT_W(32), .WID_W(8)) dut (
    .ACLK        (ACLK),
    .ARESET      (ARESET),
    .cfg_enable  (cfg_enable),
    .cfg_start   (cfg_start),
    .cfg_stop    (cfg_stop),
    .cfg_mode    (cfg_mode),
    .cfg_delay   (cfg_delay),
    .cfg_period  (cfg_period),
    .cfg_count   (cfg_count),
    .cfg_width   (cfg_width),
    .ext_trig_in (ext_trig_in),
    .trig_out    (trig_out),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun),
    .trig_cnt    (trig_cnt)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // One burst scenario: cycle 0 is the start cycle; bit k of a mask refers to cycle k.
  typedef struct {
    logic        mode;
    logic [31:0] delay;
    logic [31:0] period;
    logic [31:0] count;
    logic [7:0]  width;
    logic [63:0] ext_mask;
    int          stop_cyc;
    logic [63:0] pulse_mask;
    int          busy_last;
    logic        exp_done;
    logic        exp_ovr;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs[5];

  localparam int RUN_CYC = 40;

  initial begin
    int hi_cnt;
    int run_len;
    int max_run;

    // mode delay period count width  ext_mask  stop  pulse_mask  busy_last done ovr cnt
    vecs[0] = '{1'b0, 32'd3, 32'd4, 32'd3, 8'd2, 64'h0,       -1, 64'h0003_0C30, 17, 1'b1, 1'b0, 32'd3};
    vecs[1] = '{1'b0, 32'd0, 32'd0, 32'd0, 8'd0, 64'h0,       10, 64'h0000_02AA, 10, 1'b0, 1'b0, 32'd5};
    vecs[2] = '{1'b1, 32'd2, 32'd5, 32'd2, 8'd1, 64'h10_0120, -1, 64'h0080_0100, 23, 1'b1, 1'b1, 32'd2};
    vecs[3] = '{1'b0, 32'd1, 32'd1, 32'd2, 8'd3, 64'h0,       -1, 64'h0000_01DC,  8, 1'b1, 1'b0, 32'd2};
    vecs[4] = '{1'b1, 32'd0, 32'd2, 32'd0, 8'd2, 64'h408,     15, 64'h0000_1830, 15, 1'b0, 1'b0, 32'd2};

    ARESET      = 1'b1;
    cfg_enable  = 1'b1;
    cfg_start   = 1'b0;
    cfg_stop    = 1'b0;
    cfg_mode    = 1'b0;
    cfg_delay   = '0;
    cfg_period  = '0;
    cfg_count   = '0;
    cfg_width   = '0;
    ext_trig_in = 1'b0;

    // Reset state
    @(negedge ACLK);
    @(negedge ACLK);
    check("rst_trig_out", trig_out, 0);
    check("rst_busy",     busy,     0);
    check("rst_done",     done,     0);
    check("rst_overrun",  overrun,  0);
    check("rst_trig_cnt", trig_cnt, 0);
    ARESET = 1'b0;
    @(negedge ACLK);
    @(negedge ACLK);

    // Table-driven bursts
    for (int s = 0; s < 5; s++) begin
      cfg_mode   = vecs[s].mode;
      cfg_delay  = vecs[s].delay;
      cfg_period = vecs[s].period;
      cfg_count  = vecs[s].count;
      cfg_width  = vecs[s].width;
      for (int k = 0; k < RUN_CYC; k++) begin
        if (k > 0) @(negedge ACLK);
        check($sformatf("v%0d_trig_c%0d", s, k), trig_out, vecs[s].pulse_mask[k]);
        check($sformatf("v%0d_busy_c%0d", s, k), busy, (k >= 1 && k <= vecs[s].busy_last) ? 1 : 0);
        cfg_start   = (k == 0);
        cfg_stop    = (k == vecs[s].stop_cyc);
        ext_trig_in = vecs[s].ext_mask[k];
      end
      @(negedge ACLK);
      cfg_start   = 1'b0;
      cfg_stop    = 1'b0;
      ext_trig_in = 1'b0;
      check($sformatf("v%0d_done", s),     done,     vecs[s].exp_done);
      check($sformatf("v%0d_overrun", s),  overrun,  vecs[s].exp_ovr);
      check($sformatf("v%0d_trig_cnt", s), trig_cnt, vecs[s].exp_cnt);
      check($sformatf("v%0d_idle", s),     busy,     0);
    end

    // Width changed mid-burst must not affect the running burst
    cfg_mode = 1'b0; cfg_delay = 32'd0; cfg_width = 8'd2; cfg_period = 32'd1; cfg_count = 32'd3;
    hi_cnt = 0; run_len = 0; max_run = 0;
    for (int k = 0; k < 30; k++) begin
      if (k > 0) @(negedge ACLK);
      if (trig_out === 1'b1) begin
        hi_cnt++;
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
      cfg_start = (k == 0);
      cfg_width = (k >= 3) ? 8'd7 : 8'd2;
    end
    @(negedge ACLK);
    cfg_start = 1'b0;
    check("wchg_high_cycles", hi_cnt,   6);
    check("wchg_max_width",   max_run,  2);
    check("wchg_trig_cnt",    trig_cnt, 3);
    check("wchg_done",        done,     1);

    // Asynchronous reset during PULSE
    cfg_mode = 1'b0; cfg_delay = 32'd0; cfg_width = 8'd5; cfg_period = 32'd1; cfg_count = 32'd0;
    cfg_start = 1'b1;
    @(negedge ACLK);
    cfg_start = 1'b0;
    @(negedge ACLK);
    check("arst_pre_trig", trig_out, 1);
    check("arst_pre_cnt",  trig_cnt, 1);
    ARESET = 1'b1;
    #1;
    check("arst_trig_out", trig_out, 0);
    check("arst_busy",     busy,     0);
    check("arst_trig_cnt", trig_cnt, 0);
    check("arst_done",     done,     0);
    check("arst_overrun",  overrun,  0);
    @(negedge ACLK);
    ARESET = 1'b0;
    cfg_start = 1'b1;
    @(negedge ACLK);
    cfg_start = 1'b0;
    check("arst_restart_trig", trig_out, 1);
    check("arst_restart_cnt",  trig_cnt, 1);
    cfg_stop = 1'b1;
    @(negedge ACLK);
    cfg_stop = 1'b0;
    check("stop_trig_out", trig_out, 0);
    check("stop_busy",     busy,     0);
    check("stop_cnt_held", trig_cnt, 1);

    // Start and stop together in IDLE: stop wins
    cfg_mode = 1'b1;
    cfg_start = 1'b1; cfg_stop = 1'b1;
    @(negedge ACLK);
    cfg_start = 1'b0; cfg_stop = 1'b0;
    check("startstop_busy", busy,     0);
    check("startstop_cnt",  trig_cnt, 1);

    // Start while disabled is ignored
    cfg_enable = 1'b0; cfg_start = 1'b1;
    @(negedge ACLK);
    cfg_enable = 1'b1; cfg_start = 1'b0;
    check("dis_start_busy", busy, 0);

    // Start into ARMED, then a second start while busy is ignored
    cfg_start = 1'b1;
    @(negedge ACLK);
    cfg_start = 1'b0;
    check("armed_busy", busy,     1);
    check("armed_cnt",  trig_cnt, 0);
    cfg_mode = 1'b0;
    cfg_start = 1'b1;
    @(negedge ACLK);
    cfg_start = 1'b0;
    check("busy_start_trig", trig_out, 0);
    check("busy_start_busy", busy,     1);
    check("busy_start_cnt",  trig_cnt, 0);

    // External edge from ARMED with zero delay, then enable drops mid-pulse
    ext_trig_in = 1'b1;
    @(negedge ACLK);
    ext_trig_in = 1'b0;
    check("ext_pulse_trig", trig_out, 1);
    check("ext_pulse_cnt",  trig_cnt, 1);
    cfg_enable = 1'b0;
    @(negedge ACLK);
    cfg_enable = 1'b1;
    check("dis_trig_out", trig_out, 0);
    check("dis_busy",     busy,     0);
    check("dis_cnt_held", trig_cnt, 1);
    check("dis_done",     done,     0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
